// File: rtl/mod_operand_sequencer.sv
// mod_operand_sequencer
//   Handshake front-end for the combinational modulus stage in the sprite
//   datapath. Accepts a numerator/denominator pair over valid/ready, drives
//   it onto the modulus stage operands, holds it for SETTLE_CYCLES cycles,
//   then captures the remainder and divide-by-zero flag and presents the
//   result downstream over valid/ready (held stable under backpressure).
//
//   Parameters
//     WIDTH          operand/result width in bits
//     SETTLE_CYCLES  cycles the operands are held before capture (1..15)
//
//   Ports
//     clk, rst_n                   clock (rising edge), async active-low reset
//     in_valid/in_ready            upstream handshake
//     in_num, in_den               incoming operand pair
//     mod_num, mod_den             operands driven to the modulus stage
//     mod_result, mod_error        remainder / divide-by-zero from the stage
//     out_valid/out_ready          downstream handshake
//     out_num, out_den             operand pair belonging to the result
//     out_mod, out_err             captured remainder / divide-by-zero flag
//     err_count                    saturating error count (optional)
//     busy                         high whenever the FSM is not idle
//
//   Optional feature: define MOD_SEQ_ERRCNT_EN to add the err_count output.

module mod_operand_sequencer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_den,
  output logic [WIDTH-1:0] mod_num,
  output logic [WIDTH-1:0] mod_den,
  input  logic [WIDTH-1:0] mod_result,
  input  logic             mod_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_num,
  output logic [WIDTH-1:0] out_den,
  output logic [WIDTH-1:0] out_mod,
  output logic             out_err,
`ifdef MOD_SEQ_ERRCNT_EN
  output logic [7:0]       err_count,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic             r_rdy_en;
  logic [WIDTH-1:0] r_mod_num;
  logic [WIDTH-1:0] r_mod_den;
  logic [WIDTH-1:0] r_out_num;
  logic [WIDTH-1:0] r_out_den;
  logic [WIDTH-1:0] r_out_mod;
  logic             r_out_err;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_cap_err;

  // State stays IDLE during reset, so ready is additionally gated by a flop
  // that only rises on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  assign in_ready  = r_rdy_en && (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign mod_num   = r_mod_num;
  assign mod_den   = r_mod_den;
  assign out_num   = r_out_num;
  assign out_den   = r_out_den;
  assign out_mod   = r_out_mod;
  assign out_err   = r_out_err;
  assign out_valid = r_out_valid;

  // Local zero check covers a modulus stage whose error output is undefined.
  assign w_cap_err = mod_error || (r_mod_den == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_accept = 1'b1;
          w_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == LAST_CNT) begin
          w_capture = 1'b1;
          w_next    = HOLD;
        end
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_mod_num   <= '0;
      r_mod_den   <= '0;
      r_out_num   <= '0;
      r_out_den   <= '0;
      r_out_mod   <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mod_num <= in_num;
        r_mod_den <= in_den;
        r_out_num <= in_num;
        r_out_den <= in_den;
        r_cnt     <= '0;
      end else if (r_state == SETTLE && !w_capture) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_capture) begin
        r_out_valid <= 1'b1;
        if (w_cap_err) begin
          r_out_mod <= '0;
          r_out_err <= 1'b1;
        end else begin
          r_out_mod <= mod_result;
          r_out_err <= 1'b0;
        end
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MOD_SEQ_ERRCNT_EN
  logic [7:0] r_err_count;

  // Saturates at 255 rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_capture && w_cap_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_mod_operand_sequencer.sv
// tb_mod_operand_sequencer
//   Self-checking bench for mod_operand_sequencer. A behavioural modulus
//   stage answers the DUT's operand outputs; expected results are queued
//   when a pair is accepted and popped when the result handshake occurs.
`timescale 1ns/1ps

module tb_mod_operand_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned SC = 2;

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] md;
    logic         err;
  } sb_entry_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_num = '0;
  logic [W-1:0] in_den = '0;
  logic [W-1:0] mod_num;
  logic [W-1:0] mod_den;
  logic [W-1:0] mod_result;
  logic         mod_error;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_num;
  logic [W-1:0] out_den;
  logic [W-1:0] out_mod;
  logic         out_err;
  logic         busy;
`ifdef MOD_SEQ_ERRCNT_EN
  logic [7:0]   err_count;
  int           exp_ecnt = 0;
`endif

  logic         force_no_err = 1'b0;
  int           errors = 0;
  int           checks = 0;
  sb_entry_t    sb[$];
  sb_entry_t    mon_e;

  always #5 clk = ~clk;

  mod_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_den     (in_den),
    .mod_num    (mod_num),
    .mod_den    (mod_den),
    .mod_result (mod_result),
    .mod_error  (mod_error),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_num    (out_num),
    .out_den    (out_den),
    .out_mod    (out_mod),
    .out_err    (out_err),
`ifdef MOD_SEQ_ERRCNT_EN
    .err_count  (err_count),
`endif
    .busy       (busy)
  );

  // Behavioural modulus stage; returns garbage on zero divisor and can be
  // told to suppress its error flag.
  always_comb begin
    mod_result = 16'hBEEF;
    mod_error  = 1'b0;
    if (mod_den == '0) begin
      mod_error = !force_no_err;
    end else begin
      mod_result = mod_num % mod_den;
    end
  end

  // Scoreboard monitor: the transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got out_valid=1 num=%0d den=%0d, required no pending result", out_num, out_den);
      end else begin
        mon_e = sb.pop_front();
        if (out_num !== mon_e.num || out_den !== mon_e.den || out_mod !== mon_e.md || out_err !== mon_e.err) begin
          errors++;
          $display("FAIL sb_result: got num=%0d den=%0d mod=%0d err=%0b, required num=%0d den=%0d mod=%0d err=%0b",
                   out_num, out_den, out_mod, out_err, mon_e.num, mon_e.den, mon_e.md, mon_e.err);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Present a pair and wait (bounded) for acceptance; queue its expectation.
  task automatic send(input logic [W-1:0] num, input logic [W-1:0] den);
    sb_entry_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_num   = num;
    in_den   = den;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        e.num = num;
        e.den = den;
        e.md  = (den == '0) ? '0 : (num % den);
        e.err = (den == '0);
        sb.push_back(e);
`ifdef MOD_SEQ_ERRCNT_EN
        if (e.err && exp_ecnt < 255) exp_ecnt++;
`endif
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance of %0d/%0d", num, den);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/busy/err=%b, required 0000", {in_ready, out_valid, busy, out_err});
    end
    checks++;
    if ({mod_num, mod_den, out_num, out_den, out_mod} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h %h, required all zero", mod_num, mod_den, out_num, out_den, out_mod);
    end
`ifdef MOD_SEQ_ERRCNT_EN
    exp_ecnt = 0;
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_errcnt: got %0d, required 0", err_count);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(16'd15, 16'd2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || mod_num !== 16'd15 || mod_den !== 16'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_settle: got busy=%b rdy=%b mod_num=%0d mod_den=%0d vld=%b, required 1 0 15 2 0",
               busy, in_ready, mod_num, mod_den, out_valid);
    end
    for (int i = 1; i < SC; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_early_valid: got out_valid=%b at accept+%0d, required 0", out_valid, i);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got out_valid=%b at accept+%0d, required 1", out_valid, SC);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_return: got rdy=%b vld=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    drain();
  endtask

  task automatic test_div_zero();
    out_ready    = 1'b1;
    force_no_err = 1'b0;
    send(16'd15, 16'd0);
    drain();
    force_no_err = 1'b1;
    send(16'd15, 16'd0);
    drain();
    force_no_err = 1'b0;
  endtask

  task automatic test_wide();
    out_ready = 1'b1;
    send(16'd40000, 16'd7);
    send(16'd65535, 16'd256);
    drain();
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    out_ready = 1'b0;
    send(16'd50, 16'd7);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_valid_timeout: got out_valid=0, required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_num   = 16'd9;
    in_den   = 16'd4;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_num !== 16'd50 || out_den !== 16'd7 ||
          out_mod !== 16'd1 || out_err !== 1'b0 || mod_num !== 16'd50) begin
        errors++;
        $display("FAIL bp_hold: got vld=%b rdy=%b num=%0d den=%0d mod=%0d err=%b mod_num=%0d, required 1 0 50 7 1 0 50",
                 out_valid, in_ready, out_num, out_den, out_mod, out_err, mod_num);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd9, 16'd4);
    drain();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b1;
    send(16'd100, 16'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_err} !== 4'b0000 ||
        {mod_num, mod_den, out_num, out_den, out_mod} !== '0) begin
      errors++;
      $display("FAIL midop_reset: got rdy=%b vld=%b busy=%b err=%b mod_num=%0d out_num=%0d, required all zero",
               in_ready, out_valid, busy, out_err, mod_num, out_num);
    end
    sb.delete();
`ifdef MOD_SEQ_ERRCNT_EN
    exp_ecnt = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < SC + 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_stale: got out_valid=%b after release, required 0", out_valid);
      end
    end
    send(16'd100, 16'd3);
    drain();
  endtask

`ifdef MOD_SEQ_ERRCNT_EN
  task automatic test_errcnt();
    out_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      send(16'(i), 16'd0);
    end
    drain();
    @(negedge clk);
    checks++;
    if (err_count !== 8'(exp_ecnt) || err_count !== 8'd255) begin
      errors++;
      $display("FAIL errcnt_sat: got %0d, required %0d", err_count, exp_ecnt);
    end
    send(16'd10, 16'd3);
    drain();
    @(negedge clk);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL errcnt_hold: got %0d, required 255", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_wide();
    test_backpressure();
    test_reset_midop();
`ifdef MOD_SEQ_ERRCNT_EN
    test_errcnt();
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_operand_sequencer.md
Name: mod_operand_sequencer

Overview:
- Handshake front-end for the 16-bit combinational modulus stage in the sprite datapath.
- Accepts numerator/denominator pairs from the sprite-position logic over valid/ready.
- Drives the pair onto the modulus stage's operand inputs, holds it stable for a fixed settle window, then captures the remainder and divide-by-zero error.
- Presents the result downstream over valid/ready, with result held under backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SETTLE_CYCLES, 2, cycles the operands are held before capture. Legal range is 1..15; 0 is illegal.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  block can accept a pair.
- in_num  input  WIDTH  numerator.
- in_den  input  WIDTH  denominator.
- mod_num  output  WIDTH  numerator driven to the modulus stage.
- mod_den  output  WIDTH  denominator driven to the modulus stage.
- mod_result  input  WIDTH  remainder returned by the modulus stage.
- mod_error  input  1  divide-by-zero flag returned by the modulus stage.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_num  output  WIDTH  numerator of this result.
- out_den  output  WIDTH  denominator of this result.
- out_mod  output  WIDTH  remainder.
- out_err  output  1  divide-by-zero flag.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state=IDLE, settle counter=0.
  - mod_num, mod_den, out_num, out_den, out_mod = 0.
  - out_err=0, out_valid=0, busy=0.
  - in_ready=0 while rst_n is low; in_ready=1 from the first clock edge after release.
- State machine: IDLE -> SETTLE -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - On clock edge with in_valid=1: latch in_num/in_den into mod_num/mod_den and out_num/out_den, clear counter, go to SETTLE.
- SETTLE:
  - in_ready=0, mod_num/mod_den held constant, counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1, capture into out_mod/out_err, set out_valid=1, go to HOLD.
  - Capture rule when mod_error=1 OR mod_den==0: out_mod=0, out_err=1. The local zero check guards against a modulus stage whose error output is undefined.
  - Otherwise: out_mod=mod_result, out_err=0.
- HOLD:
  - in_ready=0.
  - out_valid and all out_* held stable until out_ready=1.
  - On the edge with out_valid & out_ready: clear out_valid, go to IDLE.
  - A new pair cannot be accepted on the same edge.
- Latency: accept at edge N gives out_valid high from edge N+SETTLE_CYCLES.
- Throughput: at most one pair per SETTLE_CYCLES+2 cycles when out_ready is held high.
- in_valid during SETTLE/HOLD is ignored; upstream must hold its data per valid/ready rules.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-SETTLE or mid-HOLD: the pending pair is dropped and all outputs return to reset values immediately. No partial result is ever emitted.
- No arithmetic is performed here; widths pass through unchanged. mod_result bits above WIDTH do not exist.

Optional Feature:
- Macro: MOD_SEQ_ERRCNT_EN.
- Defined:
  - Adds output err_count [7:0], resetting to 0.
  - Increments by 1 on each capture with out_err=1.
  - Saturates at 255; never wraps.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic: in_num=15, in_den=2, accept at edge 0, out_ready=1, SETTLE_CYCLES=2 -> out_valid high from edge 2; out_mod=1, out_err=0, out_num=15, out_den=2; in_ready back to 1 after the handshake.
- Divide by zero: in_num=15, in_den=0 -> out_mod=0, out_err=1, even when the model forces mod_error=0.
- Wide operands: in_num=40000, in_den=7 -> out_mod=2. Then in_num=65535, in_den=256 -> out_mod=255.
- Backpressure: out_ready=0 for 10 cycles after out_valid, in_valid held high with a second pair (9 % 4) -> out_* stable and in_ready=0 throughout. After out_ready=1, the second pair is accepted and returns out_mod=1.
- Reset mid-op: rst_n low one cycle after accept of 100 % 3 -> all outputs 0 immediately; no out_valid after release; the next pair 100 % 3 returns out_mod=1.
- With MOD_SEQ_ERRCNT_EN: 260 consecutive den=0 pairs -> err_count reads 255 and stays there. A following 10 % 3 leaves err_count=255 with out_mod=1.
